// File: rtl/store_buffer.sv
// Store buffer between EXE/MEM and the memory stage: queues stores, drains them
// in the background, forwards loads that hit a buffered word, and lets load misses bypass pending stores.
module store_buffer #(
    parameter int ADDRESS_LEN = 32,
    parameter int WORD_LEN    = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_r_en,
    input  logic                   in_w_en,
    input  logic [ADDRESS_LEN-1:0] in_addr,
    input  logic [WORD_LEN-1:0]    in_wdata,
    output logic                   freeze,
    output logic                   MEM_R_EN,
    output logic                   MEM_W_EN,
    output logic [ADDRESS_LEN-1:0] ALU_Res,
    output logic [WORD_LEN-1:0]    Val_Rm,
    input  logic                   mem_ready,
    input  logic [WORD_LEN-1:0]    mem_rdata,
    output logic                   rd_valid,
    output logic [WORD_LEN-1:0]    rd_data,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TAG_W = ADDRESS_LEN - 2;

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [TAG_W-1:0]     tag_q  [DEPTH];
    logic [TAG_W-1:0]     tag_d  [DEPTH];
    logic [WORD_LEN-1:0]  data_q [DEPTH];
    logic [WORD_LEN-1:0]  data_d [DEPTH];
    logic [DEPTH-1:0]     match;
    logic                 enq, deq, full, forward_hit;
    logic [WORD_LEN-1:0]  fwd_data;

    assign full = (count_q == CNT_W'(DEPTH));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [PTR_W-1:0] age;
            // Entry is live when its distance from head is below count.
            assign age        = PTR_W'(gi) - head_q;
            assign match[gi]  = (CNT_W'(age) < count_q) && (tag_q[gi] == in_addr[ADDRESS_LEN-1:2]);

            always_comb begin
                tag_d[gi]  = tag_q[gi];
                data_d[gi] = data_q[gi];
                if (enq && (tail_q == PTR_W'(gi))) begin
                    tag_d[gi]  = in_addr[ADDRESS_LEN-1:2];
                    data_d[gi] = in_wdata;
                end
            end

            always_ff @(posedge clk) begin
                tag_q[gi]  <= tag_d[gi];
                data_q[gi] <= data_d[gi];
            end
        end
    endgenerate

    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        logic             hit_any;
        logic [PTR_W-1:0] idx;
        hit_any  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (match[idx]) begin
                hit_any  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
        forward_hit = in_r_en && hit_any;
    end

    always_comb begin
        state_d  = state_q;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        ALU_Res  = '0;
        Val_Rm   = '0;
        freeze   = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        deq      = 1'b0;
        enq      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_r_en && !forward_hit) begin
                    MEM_R_EN = 1'b1;
                    ALU_Res  = in_addr;
                    if (mem_ready) begin
                        rd_valid = 1'b1;
                        rd_data  = mem_rdata;
                    end else begin
                        freeze  = 1'b1;
                        state_d = LOAD;
                    end
                end else if (count_q != '0) begin
                    MEM_W_EN = 1'b1;
                    ALU_Res  = {tag_q[head_q], 2'b00};
                    Val_Rm   = data_q[head_q];
                    if (mem_ready) deq = 1'b1;
                    else           state_d = DRAIN;
                end
            end
            DRAIN: begin
                MEM_W_EN = 1'b1;
                ALU_Res  = {tag_q[head_q], 2'b00};
                Val_Rm   = data_q[head_q];
                if (mem_ready) begin
                    deq     = 1'b1;
                    state_d = IDLE;
                end
                // The miss waits and is issued from IDLE after the store retires.
                if (in_r_en && !forward_hit) freeze = 1'b1;
            end
            LOAD: begin
                MEM_R_EN = 1'b1;
                ALU_Res  = in_addr;
                if (mem_ready) begin
                    rd_valid = 1'b1;
                    rd_data  = mem_rdata;
                    state_d  = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (forward_hit) begin
            rd_valid = 1'b1;
            rd_data  = fwd_data;
        end

        if (in_w_en) begin
            if (full) freeze = 1'b1;
            else      enq    = 1'b1;
        end

        if (rst) begin
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b0;
            ALU_Res  = '0;
            Val_Rm   = '0;
            freeze   = 1'b0;
            rd_valid = 1'b0;
            rd_data  = '0;
        end
    end

    assign head_d  = head_q + PTR_W'(deq);
    assign tail_d  = tail_q + PTR_W'(enq);
    assign count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    assign empty   = rst || ((count_q == '0) && (state_q == IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule
